// File: rtl/json_seq_ctrl.sv
// json_seq_ctrl: run-control sequencer for a 4-bit Johnson display counter.
// Single-clock prescaler with selectable rate, IDLE/RUN/PAUSE control FSM,
// forward/reverse stepping, illegal-state recovery and 7-segment decode.
// Optional feature macro: JSON_STEP_CNT_EN adds a saturating advance counter
// on output step_cnt_o.
module json_seq_ctrl #(
  parameter int DIV_W = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        step_i,
  input  logic        dir_i,
  input  logic [1:0]  rate_i,
  output logic [3:0]  json_o,
  output logic [0:6]  q,
  output logic        busy_o,
  output logic        wrap_o,
`ifdef JSON_STEP_CNT_EN
  output logic [15:0] step_cnt_o,
`endif
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [DIV_W-1:0]   rate_mask;
  logic [3:0]         json_q, json_d;
  logic [3:0]         shifted;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic               legal;
  logic               tick;
  logic               step_req;
  logic               clear_req;
  logic               advance;

`ifdef JSON_STEP_CNT_EN
  logic [15:0]        cnt_q, cnt_d;
`endif

  // Only the eight Johnson codes are legal; anything else must be recovered.
  always_comb begin
    legal = 1'b0;
    case (json_q)
      4'b0000, 4'b0001, 4'b0011, 4'b0111,
      4'b1111, 4'b1110, 4'b1100, 4'b1000: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  // Tick when the low (DIV_W - 2*rate) prescaler bits are all ones while running.
  always_comb begin
    rate_mask = {DIV_W{1'b1}} >> {rate_i, 1'b0};
    tick      = (state_q == RUN) && ((presc_q & rate_mask) == rate_mask);
    shifted   = dir_i ? {~json_q[0], json_q[3:1]} : {json_q[2:0], ~json_q[3]};
  end

  // Control decisions with priority stop > start > step, and prescaler next value.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    step_req  = 1'b0;
    clear_req = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (stop_i) begin
          state_d = IDLE;
        end else if (start_i) begin
          state_d = RUN;
        end else if (step_i) begin
          step_req = 1'b1;
          state_d  = PAUSE;
        end
      end
      RUN: begin
        presc_d = presc_q + 1'b1;
        if (stop_i) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (stop_i) begin
          state_d   = IDLE;
          presc_d   = '0;
          clear_req = 1'b1;
        end else if (start_i) begin
          state_d = RUN;
        end else if (step_i) begin
          step_req = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
  end

  // Datapath next state: shift on advance, recover illegal codes to 0000, flag wrap.
  always_comb begin
    advance = tick | step_req;
    json_d  = json_q;
    wrap_d  = 1'b0;
    err_d   = err_q | ~legal;
    busy_d  = (state_d == RUN);
    if (clear_req) begin
      json_d = 4'b0000;
    end else if (advance) begin
      if (legal) begin
        json_d = shifted;
        wrap_d = (shifted == 4'b0000);
      end else begin
        json_d = 4'b0000;
      end
    end
  end

`ifdef JSON_STEP_CNT_EN
  // Saturating count of advances, cleared when returning to idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_req) begin
      cnt_d = 16'h0000;
    end else if (advance && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end
  end
`endif

  // Single state register for the FSM, prescaler, Johnson value and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      json_q  <= 4'b0000;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef JSON_STEP_CNT_EN
      cnt_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      json_q  <= json_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
`ifdef JSON_STEP_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Active-low segment decode (q[0]=a .. q[6]=g) of the displayed digit.
  always_comb begin
    case (json_q)
      4'b0000: q = 7'b0000001;
      4'b0001: q = 7'b1001111;
      4'b0011: q = 7'b0010010;
      4'b0111: q = 7'b0000110;
      4'b1111: q = 7'b1001100;
      4'b1110: q = 7'b0100100;
      4'b1100: q = 7'b0100000;
      4'b1000: q = 7'b0001111;
      default: q = 7'b1111111;
    endcase
  end

  assign json_o = json_q;
  assign busy_o = busy_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;
`ifdef JSON_STEP_CNT_EN
  assign step_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_json_seq_ctrl.sv
// Testbench for json_seq_ctrl (DIV_W=8): directed vector table, hand-written
// corner-case sequences and randomized pulses against a digit-level model.
module tb_json_seq_ctrl;

  localparam int DIV_W = 8;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clk;
  logic       rst;
  logic       startI, stopI, stepI, dirI;
  logic [1:0] rateI;
  logic [3:0] jsonO;
  logic [0:6] qO;
  logic       busyO, wrapO, errO;
`ifdef JSON_STEP_CNT_EN
  logic [15:0] stepCntO;
`endif

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: digit index into the Johnson sequence (-1 = illegal code).
  logic [3:0] seqTbl [8];
  logic [0:6] segTbl [8];
  int         mMode;
  int         mIdx;
  logic [3:0] mRaw;
  int         mPre;
  bit         mErr;
  bit         mWrap;
  int         mCnt;

  typedef struct {
    bit         start;
    bit         stop;
    bit         step;
    bit         dir;
    logic [1:0] rate;
    logic [3:0] json;
    logic [0:6] seg;
    bit         busy;
    bit         wrap;
  } vec_t;

  vec_t tbl [12];

  json_seq_ctrl #(.DIV_W(DIV_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (startI),
    .stop_i  (stopI),
    .step_i  (stepI),
    .dir_i   (dirI),
    .rate_i  (rateI),
    .json_o  (jsonO),
    .q       (qO),
    .busy_o  (busyO),
    .wrap_o  (wrapO),
`ifdef JSON_STEP_CNT_EN
    .step_cnt_o (stepCntO),
`endif
    .err_o   (errO)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] expJson();
    return (mIdx >= 0) ? seqTbl[mIdx] : mRaw;
  endfunction

  function automatic logic [0:6] expSeg();
    return (mIdx >= 0) ? segTbl[mIdx] : 7'b1111111;
  endfunction

  task automatic modelReset();
    mMode = M_IDLE;
    mIdx  = 0;
    mRaw  = 4'b0000;
    mPre  = 0;
    mErr  = 1'b0;
    mWrap = 1'b0;
    mCnt  = 0;
  endtask

  // One clock edge of behaviour, computed from the run-control rules.
  task automatic modelStep();
    int period;
    bit tick;
    bit adv;
    period = 1 << (DIV_W - 2 * int'(rateI));
    tick   = (mMode == M_RUN) && ((mPre % period) == period - 1);
    adv    = 1'b0;
    mWrap  = 1'b0;
    if (mIdx < 0) mErr = 1'b1;
    case (mMode)
      M_IDLE: begin
        if (stopI) begin
        end else if (startI) begin
          mMode = M_RUN;
        end else if (stepI) begin
          adv   = 1'b1;
          mMode = M_PAUSE;
        end
      end
      M_RUN: begin
        adv  = tick;
        mPre = (mPre + 1) % (1 << DIV_W);
        if (stopI) mMode = M_PAUSE;
      end
      default: begin
        if (stopI) begin
          mMode = M_IDLE;
          mPre  = 0;
          mIdx  = 0;
          mCnt  = 0;
        end else if (startI) begin
          mMode = M_RUN;
        end else if (stepI) begin
          adv = 1'b1;
        end
      end
    endcase
    if (adv) begin
      if (mIdx < 0) begin
        mIdx = 0;
      end else begin
        mIdx  = (mIdx + (dirI ? 7 : 1)) % 8;
        mWrap = (mIdx == 0);
      end
      if (mCnt < 65535) mCnt++;
    end
  endtask

  task automatic checkAll();
    checkOutput("model_json", {12'h0, jsonO}, {12'h0, expJson()});
    checkOutput("model_seg", {9'h0, qO}, {9'h0, expSeg()});
    checkOutput("model_busy", {15'h0, busyO}, {15'h0, (mMode == M_RUN)});
    checkOutput("model_wrap", {15'h0, wrapO}, {15'h0, mWrap});
    checkOutput("model_err", {15'h0, errO}, {15'h0, mErr});
`ifdef JSON_STEP_CNT_EN
    checkOutput("model_stepcnt", stepCntO, mCnt[15:0]);
`endif
  endtask

  // Apply current inputs across one rising edge, then check on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
    startI = 1'b0;
    stopI  = 1'b0;
    stepI  = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int prevJson;
    int k;
    int wraps;
    int n;
    bit found;
    logic [3:0] frozen;

    seqTbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    segTbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};

    //            start stop step dir rate   json     seg         busy wrap
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0001, 7'b1001111, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0011, 7'b0010010, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0001, 7'b1001111, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0000, 7'b0000001, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 7'b0001111, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 7'b0001111, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 7'b0000001, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 7'b0000001, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 7'b0000001, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 7'b0000001, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 7'b0000001, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 7'b0000001, 1'b0, 1'b0};

    rst    = 1'b0;
    startI = 1'b0;
    stopI  = 1'b0;
    stepI  = 1'b0;
    dirI   = 1'b0;
    rateI  = 2'd3;
    modelReset();

    applyReset();
    checkOutput("reset_json", {12'h0, jsonO}, 16'h0000);
    checkOutput("reset_seg", {9'h0, qO}, 16'h0001);

    // Directed vector table: stepping, wrap in reverse, priorities, step ignored in RUN.
    for (int i = 0; i < 12; i++) begin
      startI = tbl[i].start;
      stopI  = tbl[i].stop;
      stepI  = tbl[i].step;
      dirI   = tbl[i].dir;
      rateI  = tbl[i].rate;
      applyStimulus();
      checkOutput($sformatf("tbl%0d_json", i), {12'h0, jsonO}, {12'h0, tbl[i].json});
      checkOutput($sformatf("tbl%0d_seg", i), {9'h0, qO}, {9'h0, tbl[i].seg});
      checkOutput($sformatf("tbl%0d_busy", i), {15'h0, busyO}, {15'h0, tbl[i].busy});
      checkOutput($sformatf("tbl%0d_wrap", i), {15'h0, wrapO}, {15'h0, tbl[i].wrap});
    end

    // Forward run at rate 3: one advance every 4 cycles, one wrap.
    applyReset();
    startI = 1'b1; dirI = 1'b0; rateI = 2'd3;
    applyStimulus();
    prevJson = int'(jsonO);
    k = 0;
    wraps = 0;
    for (int c = 1; c <= 32; c++) begin
      applyStimulus();
      if (wrapO) wraps++;
      if (int'(jsonO) != prevJson) begin
        checkOutput("run_interval", c[15:0], 16'(4 * (k + 1)));
        if (k < 8) checkOutput("run_seq", {12'h0, jsonO}, {12'h0, seqTbl[(k + 1) % 8]});
        k++;
        prevJson = int'(jsonO);
      end
    end
    checkOutput("run_changes", k[15:0], 16'd8);
    checkOutput("run_wraps", wraps[15:0], 16'd1);
    checkOutput("run_busy", {15'h0, busyO}, 16'd1);

    // Pause at rate 0, hold, resume: remaining period is honoured.
    stopI = 1'b1; applyStimulus();
    stopI = 1'b1; applyStimulus();
    startI = 1'b1; rateI = 2'd0; applyStimulus();
    for (int c = 0; c < 299; c++) applyStimulus();
    stopI = 1'b1; applyStimulus();
    frozen = jsonO;
    for (int c = 0; c < 100; c++) applyStimulus();
    checkOutput("pause_frozen", {12'h0, jsonO}, {12'h0, frozen});
    checkOutput("pause_busy", {15'h0, busyO}, 16'd0);
    startI = 1'b1; applyStimulus();
    n = 0;
    while (jsonO == frozen && n < 600) begin
      applyStimulus();
      n++;
    end
    checkOutput("resume_latency", n[15:0], 16'(256 - ((299 + 1) % 256)));

    // Reverse single steps from 0000 in PAUSE.
    stopI = 1'b1; applyStimulus();
    stopI = 1'b1; applyStimulus();
    stepI = 1'b1; dirI = 1'b0; applyStimulus();
    stepI = 1'b1; dirI = 1'b1; applyStimulus();
    checkOutput("rev_zero", {12'h0, jsonO}, 16'h0000);
    stepI = 1'b1; dirI = 1'b1; applyStimulus();
    checkOutput("rev_1000", {12'h0, jsonO}, 16'h0008);
    checkOutput("rev_wrap1", {15'h0, wrapO}, 16'd0);
    stepI = 1'b1; dirI = 1'b1; applyStimulus();
    checkOutput("rev_1100", {12'h0, jsonO}, 16'h000C);
    checkOutput("rev_wrap2", {15'h0, wrapO}, 16'd0);
    checkOutput("rev_seg", {9'h0, qO}, {9'h0, 7'b0100000});

    // Illegal code deposit, then run: error flag and recovery to 0000 without wrap.
    force dut.json_q = 4'b0101;
    #1;
    release dut.json_q;
    mIdx = -1;
    mRaw = 4'b0101;
    #1;
    checkOutput("ill_json", {12'h0, jsonO}, 16'h0005);
    checkOutput("ill_seg", {9'h0, qO}, {9'h0, 7'b1111111});
    startI = 1'b1; dirI = 1'b0; rateI = 2'd3; applyStimulus();
    checkOutput("ill_err", {15'h0, errO}, 16'd1);
    checkOutput("ill_seg_run", {9'h0, qO}, {9'h0, 7'b1111111});
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      applyStimulus();
      if (jsonO == 4'b0000) found = 1'b1;
    end
    checkOutput("ill_recover", {15'h0, found}, 16'd1);
    checkOutput("ill_nowrap", {15'h0, wrapO}, 16'd0);
    checkOutput("ill_err_sticky", {15'h0, errO}, 16'd1);

    // Asynchronous reset mid-run at 0111.
    stopI = 1'b1; applyStimulus();
    stopI = 1'b1; applyStimulus();
    startI = 1'b1; dirI = 1'b0; rateI = 2'd3; applyStimulus();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      applyStimulus();
      if (jsonO == 4'b0111) found = 1'b1;
    end
    checkOutput("rst_reach0111", {15'h0, found}, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_json", {12'h0, jsonO}, 16'h0000);
    checkOutput("rst_seg", {9'h0, qO}, {9'h0, 7'b0000001});
    checkOutput("rst_busy", {15'h0, busyO}, 16'd0);
    checkOutput("rst_err", {15'h0, errO}, 16'd0);
    checkOutput("rst_wrap", {15'h0, wrapO}, 16'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized pulses and levels against the model.
    for (int c = 0; c < 2000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      startI = (r < 6);
      stopI  = (r >= 6 && r < 9);
      stepI  = (r >= 9 && r < 21);
      if (($urandom % 4) == 0) startI = 1'b1;
      dirI   = $urandom_range(0, 1) == 1;
      rateI  = ($urandom_range(0, 9) == 0) ? 2'd1 : 2'($urandom_range(2, 3));
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/json_seq_ctrl.md
Name: json_seq_ctrl

Overview:
- Run-control sequencer for the 4-bit Johnson display counter (8-state ring, 7-segment readout).
- Replaces the free-running divider-clocked counter with a single-clock controlled datapath:
  - prescaler with selectable rate
  - start/stop/pause/single-step FSM
  - forward or reverse stepping
  - illegal-state recovery
  - segment decode
- Sits between board pushbutton pulse logic and the seven-segment pins.

Parameters:
- DIV_W, 25, prescaler width; base tick period is 2^DIV_W clk cycles. Must be >= 7.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse: run / resume
- stop_i  in  1  one-cycle pulse: pause / return to idle
- step_i  in  1  one-cycle pulse: single advance when not running
- dir_i  in  1  level; 0 = forward, 1 = reverse; sampled at each advance
- rate_i  in  2  tick period select: 2^(DIV_W-2*rate_i) cycles
- json_o  out  4  registered Johnson state
- q  out  7 [0:6]  segment drive, active-low, q[0]=a..q[6]=g; combinational from json_o
- busy_o  out  1  1 while FSM in RUN
- wrap_o  out  1  one-cycle pulse when an advance lands on 0000
- err_o  out  1  sticky; set when json_o is seen in an illegal state

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, json_o=0000, prescaler=0
  - busy_o=0, wrap_o=0, err_o=0
  - q=0000001
- Prescaler:
  - Counts only in RUN; holds its value in PAUSE; cleared to 0 in IDLE.
  - tick = RUN and the low (DIV_W-2*rate_i) prescaler bits are all 1.
  - Prescaler wraps naturally; a rate_i change takes effect immediately with no reload.
- Advance:
  - forward: json <= {json[2:0], ~json[3]}
  - reverse: json <= {~json[0], json[3:1]}
  - Occurs on the same edge the tick is sampled; 1-cycle latency from tick or step_i to json_o.
- Legal sequence (forward), with displayed digit:
  - 0000 -> digit 0
  - 0001 -> digit 1
  - 0011 -> digit 2
  - 0111 -> digit 3
  - 1111 -> digit 4
  - 1110 -> digit 5
  - 1100 -> digit 6
  - 1000 -> digit 7
  - 1000 wraps back to 0000
- Segment codes (q[0:6]):
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111
  - illegal state = 1111111
- Illegal json_o: err_o set on the next edge; the next advance loads 0000 instead of shifting, in either direction; no wrap_o pulse.
- wrap_o: asserted for one cycle after a legal advance whose result is 0000 (forward from 1000, or reverse from 0001).
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_i -> RUN
  - IDLE + step_i -> one advance, go to PAUSE
  - RUN + stop_i -> PAUSE; step_i ignored in RUN
  - PAUSE + start_i -> RUN; prescaler resumes from its held value
  - PAUSE + step_i -> one advance, stay in PAUSE
  - PAUSE + stop_i -> IDLE; json_o cleared to 0000, prescaler cleared
- Simultaneous pulses: priority stop_i > start_i > step_i.
- Tick and stop_i on the same cycle in RUN: the advance occurs and the FSM enters PAUSE.
- busy_o is registered and equal to (state==RUN).
- Reset mid-run: everything returns to reset values immediately; err_o is cleared only by reset.

Optional Feature:
- Macro: JSON_STEP_CNT_EN.
- Defined:
  - Adds output step_cnt_o[15:0], reset 0.
  - Increments on every advance (tick, step, or illegal recovery).
  - Saturates at 16'hFFFF.
  - Cleared on PAUSE->IDLE.
- Undefined: no port and no counter logic; all other behaviour identical.

Test Plan (DIV_W=8):
- Reset, then start_i, rate_i=3, dir_i=0 -> json_o advances every 4 cycles: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap_o pulses once, on the 0000 cycle; busy_o=1.
- Running at rate_i=0: stop_i, then hold 100 cycles -> json_o frozen and busy_o=0; start_i -> next advance exactly (256 - cycles already elapsed in the period) later.
- PAUSE, dir_i=1 at 0000: step_i x2 -> json_o=1000 then 1100; wrap_o=0; q=0100000.
- Force json_o=0101 (bench deposit), RUN -> q=1111111, err_o=1; next tick -> json_o=0000, no wrap_o; err_o stays 1.
- start_i and stop_i on the same cycle in IDLE -> state stays IDLE; json_o=0000.
- rst low mid-run at json_o=0111 -> json_o=0000 and q=0000001 immediately, without waiting for a clk edge.
